// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: writer request port and memory command/read-data port of vram_arbiter.
interface vram_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 3
);
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_adr;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] mem_adr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  modport master (
    output wr_valid, wr_adr, wr_data, mem_rdata,
    input  wr_ready, mem_adr, mem_we, mem_wdata
  );
  modport slave (
    input  wr_valid, wr_adr, wr_data, mem_rdata,
    output wr_ready, mem_adr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: display-priority single-port VRAM arbiter with a write FIFO drained into free slots.
// Define VRAM_ARB_STEAL_EN to steal one write slot per repeated display-address run.
module vram_arbiter #(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  vram_arbiter_if.slave               bus,
  input  logic [ADDR_W-1:0]           disp_adr,
  input  logic                        display_time,
  input  logic                        hsync_in,
  input  logic                        vsync_in,
  output logic [DATA_W-1:0]           pixel,
  output logic                        hsync_o,
  output logic                        vsync_o,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  logic [ADDR_W-1:0] fadr_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] fadr_d [FIFO_DEPTH];
  logic [DATA_W-1:0] fdat_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fdat_d [FIFO_DEPTH];
  logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic [PW:0]       level_q, level_d;
  logic [ADDR_W-1:0] mem_adr_q, mem_adr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d, pixel_q, pixel_d;
  logic              mem_we_q, mem_we_d;
  logic [2:0]        hs_q, hs_d, vs_q, vs_d;
  logic [1:0]        dt_q, dt_d, rd_q, rd_d;
  logic              push, empty, steal, rd_slot, wr_slot;
  assign empty        = level_q == '0;
  assign bus.wr_ready = level_q != (PW+1)'(FIFO_DEPTH);
  assign push         = bus.wr_valid && bus.wr_ready;
`ifdef VRAM_ARB_STEAL_EN
  logic [ADDR_W-1:0] last_adr_q, last_adr_d;
  logic              last_rd_q, last_rd_d;
  assign steal = display_time && last_rd_q && disp_adr == last_adr_q && !empty;
  // last_rd stays low for the rest of a repeated-address run once a steal (or prior clear) happened
  always_comb begin
    last_adr_d = disp_adr;
    last_rd_d  = rd_slot && (last_rd_q || disp_adr != last_adr_q);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      last_adr_q <= '0;
      last_rd_q  <= 1'b0;
    end else begin
      last_adr_q <= last_adr_d;
      last_rd_q  <= last_rd_d;
    end
`else
  assign steal = 1'b0;
`endif
  assign rd_slot = display_time && !steal;
  assign wr_slot = (!display_time && !empty) || steal;
  always_comb begin
    fadr_d = fadr_q;
    fdat_d = fdat_q;
    if (push) begin
      fadr_d[wp_q] = bus.wr_adr;
      fdat_d[wp_q] = bus.wr_data;
    end
    wp_d        = push ? wp_q + 1'b1 : wp_q;
    rp_d        = wr_slot ? rp_q + 1'b1 : rp_q;
    level_d     = level_q + (PW+1)'(push) - (PW+1)'(wr_slot);
    mem_we_d    = wr_slot;
    mem_adr_d   = wr_slot ? fadr_q[rp_q] : disp_adr;
    mem_wdata_d = wr_slot ? fdat_q[rp_q] : '0;
    hs_d        = {hs_q[1:0], hsync_in};
    vs_d        = {vs_q[1:0], vsync_in};
    dt_d        = {dt_q[0], display_time};
    rd_d        = {rd_q[0], rd_slot};
    pixel_d     = !dt_q[1] ? '0 : rd_q[1] ? bus.mem_rdata : pixel_q;
  end
  // pixel_q is the third display_time stage: the mask uses the value two cycles old
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      fadr_q      <= '{default: '0};
      fdat_q      <= '{default: '0};
      wp_q        <= '0;
      rp_q        <= '0;
      level_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_adr_q   <= '0;
      mem_wdata_q <= '0;
      hs_q        <= '1;
      vs_q        <= '1;
      dt_q        <= '0;
      rd_q        <= '0;
      pixel_q     <= '0;
    end else begin
      fadr_q      <= fadr_d;
      fdat_q      <= fdat_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      level_q     <= level_d;
      mem_we_q    <= mem_we_d;
      mem_adr_q   <= mem_adr_d;
      mem_wdata_q <= mem_wdata_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      dt_q        <= dt_d;
      rd_q        <= rd_d;
      pixel_q     <= pixel_d;
    end
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_adr   = mem_adr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign pixel         = pixel_q;
  assign hsync_o       = hs_q[2];
  assign vsync_o       = vs_q[2];
  assign fifo_level    = level_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed checks of reset, FIFO drain, display priority, read/sync pipeline and steal.
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        display_time = 1'b0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [13:0] disp_adr = '0;
  logic [2:0]  pixel;
  logic        hsync_o, vsync_o;
  logic [2:0]  fifo_level;
  int          errs = 0;
  int          checks = 0;
  vram_arbiter_if ifc ();
  vram_arbiter dut (
    .clk(clk), .reset(reset), .bus(ifc.slave), .disp_adr(disp_adr),
    .display_time(display_time), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .pixel(pixel), .hsync_o(hsync_o), .vsync_o(vsync_o), .fifo_level(fifo_level)
  );
  always #5 clk = ~clk;
  // synchronous memory model: read data is the low address bits, one cycle later
  always @(posedge clk) ifc.mem_rdata <= ifc.mem_adr[2:0];
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [13:0] a, input logic [2:0] d);
    ifc.wr_valid = 1'b1;
    ifc.wr_adr   = a;
    ifc.wr_data  = d;
  endtask
  initial begin
    ifc.wr_valid = 1'b0;
    ifc.wr_adr   = '0;
    ifc.wr_data  = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_we", ifc.mem_we, 0);
    chk("rst_adr", ifc.mem_adr, 0);
    chk("rst_wdata", ifc.mem_wdata, 0);
    chk("rst_pixel", pixel, 0);
    chk("rst_hs", hsync_o, 1);
    chk("rst_vs", vsync_o, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_ready", ifc.wr_ready, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    // blanking write
    push(14'h0123, 3'b101);
    tick();
    ifc.wr_valid = 1'b0;
    chk("bw_level1", fifo_level, 1);
    chk("bw_we_early", ifc.mem_we, 0);
    tick();
    chk("bw_we", ifc.mem_we, 1);
    chk("bw_adr", ifc.mem_adr, 16'h0123);
    chk("bw_data", ifc.mem_wdata, 3'b101);
    chk("bw_level0", fifo_level, 0);
    // display rise takes the slot, fall releases it next cycle
    push(14'h0042, 3'd2);
    tick();
    ifc.wr_valid = 1'b0;
    display_time = 1'b1;
    disp_adr = 14'h0010;
    chk("rise_level", fifo_level, 1);
    tick();
    chk("rise_we", ifc.mem_we, 0);
    chk("rise_adr", ifc.mem_adr, 16'h0010);
    display_time = 1'b0;
    tick();
    chk("fall_we", ifc.mem_we, 1);
    chk("fall_adr", ifc.mem_adr, 16'h0042);
    chk("fall_level", fifo_level, 0);
    // display priority: fill FIFO while visible
    display_time = 1'b1;
    for (int i = 0; i < 5; i++) begin
      disp_adr = 14'h0200 + 14'(i);
      push(14'h0100 + 14'(i), 3'(i + 1));
      chk("prio_ready", ifc.wr_ready, 16'(i < 4));
      tick();
      chk("prio_we", ifc.mem_we, 0);
    end
    for (int j = 0; j < 2; j++) begin
      disp_adr = 14'h0205 + 14'(j);
      chk("full_ready", ifc.wr_ready, 0);
      tick();
      chk("full_we", ifc.mem_we, 0);
      chk("full_level", fifo_level, 4);
    end
    display_time = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) chk("drain_ready", ifc.wr_ready, 1);
      if (k == 1) ifc.wr_valid = 1'b0;
      chk("drain_we", ifc.mem_we, 1);
      chk("drain_adr", ifc.mem_adr, 16'h0100 + 16'(k));
      chk("drain_data", ifc.mem_wdata, 16'(k + 1));
      chk("drain_level", fifo_level, k < 2 ? 16'd3 : 16'(4 - k));
    end
    tick();
    chk("empty_we", ifc.mem_we, 0);
    chk("empty_level", fifo_level, 0);
    // simultaneous push and pop at level 2
    display_time = 1'b1;
    disp_adr = 14'h0300;
    push(14'h00AA, 3'd3);
    tick();
    disp_adr = 14'h0301;
    push(14'h00BB, 3'd4);
    tick();
    chk("pp_level_pre", fifo_level, 2);
    display_time = 1'b0;
    push(14'h00CC, 3'd6);
    tick();
    ifc.wr_valid = 1'b0;
    chk("pp_level", fifo_level, 2);
    chk("pp_adr0", ifc.mem_adr, 16'h00AA);
    tick();
    chk("pp_adr1", ifc.mem_adr, 16'h00BB);
    chk("pp_level1", fifo_level, 1);
    tick();
    chk("pp_adr2", ifc.mem_adr, 16'h00CC);
    chk("pp_data2", ifc.mem_wdata, 3'd6);
    chk("pp_level0", fifo_level, 0);
    tick();
    chk("pp_we_done", ifc.mem_we, 0);
    // read pipeline and sync alignment
    display_time = 1'b1;
    disp_adr = 14'h0005;
    hsync_in = 1'b0;
    tick();
    disp_adr = 14'h0006;
    hsync_in = 1'b1;
    vsync_in = 1'b0;
    chk("rd_adr", ifc.mem_adr, 16'h0005);
    chk("rd_we", ifc.mem_we, 0);
    chk("hs_t1", hsync_o, 1);
    tick();
    vsync_in = 1'b1;
    display_time = 1'b0;
    chk("hs_t2", hsync_o, 1);
    tick();
    chk("pix_t3", pixel, 3'b101);
    chk("hs_t3", hsync_o, 0);
    chk("vs_t3", vsync_o, 1);
    tick();
    chk("pix_t4", pixel, 3'b110);
    chk("hs_t4", hsync_o, 1);
    chk("vs_t4", vsync_o, 0);
    tick();
    chk("pix_blank", pixel, 0);
    chk("vs_t5", vsync_o, 1);
`ifdef VRAM_ARB_STEAL_EN
    // one stolen write per repeated-address run; pixel holds across it
    display_time = 1'b1;
    disp_adr = 14'h0010;
    push(14'h0101, 3'd2);
    tick();
    disp_adr = 14'h0011;
    push(14'h0102, 3'd3);
    tick();
    ifc.wr_valid = 1'b0;
    disp_adr = 14'h0006;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("steal_we", ifc.mem_we, 16'(c == 1));
      if (c == 1) chk("steal_adr", ifc.mem_adr, 16'h0101);
      if (c >= 2) chk("steal_pixel", pixel, 3'd6);
    end
    chk("steal_level", fifo_level, 1);
    display_time = 1'b0;
    tick();
    chk("steal_drain_we", ifc.mem_we, 1);
    chk("steal_drain_adr", ifc.mem_adr, 16'h0102);
    tick();
    chk("steal_done_we", ifc.mem_we, 0);
`endif
    // reset mid-drain at level 3
    display_time = 1'b1;
    hsync_in = 1'b0;
    vsync_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      disp_adr = 14'(i + 1);
      push(14'h03F0 + 14'(i), 3'(i));
      tick();
    end
    ifc.wr_valid = 1'b0;
    display_time = 1'b0;
    tick();
    chk("md_level", fifo_level, 3);
    chk("md_we", ifc.mem_we, 1);
    chk("md_pixel", pixel, 3'd3);
    chk("md_hs", hsync_o, 0);
    #2 reset = 1'b0;
    #1;
    chk("mrst_we", ifc.mem_we, 0);
    chk("mrst_pixel", pixel, 0);
    chk("mrst_hs", hsync_o, 1);
    chk("mrst_vs", vsync_o, 1);
    chk("mrst_level", fifo_level, 0);
    chk("mrst_ready", ifc.wr_ready, 1);
    tick();
    reset = 1'b1;
    hsync_in = 1'b1;
    vsync_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_we", ifc.mem_we, 0);
      chk("post_rst_level", fifo_level, 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
